// File: rtl/dvsd_cmp_stats_if.sv
// Handshake and snapshot bundle between a comparator-result producer/snapshot consumer
// (master) and the dvsd_cmp_stats block (slave).
interface dvsd_cmp_stats_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             less_than;
  logic             equal_to;
  logic             greater_than;
  logic             clr;
  logic             snap_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [CNT_W-1:0] snap_lt;
  logic [CNT_W-1:0] snap_eq;
  logic [CNT_W-1:0] snap_gt;
  logic [CNT_W-1:0] snap_err;
  logic             eq_run;

  modport master (
    output in_valid, less_than, equal_to, greater_than, clr, snap_req, snap_ready,
    input  in_ready, snap_valid, snap_lt, snap_eq, snap_gt, snap_err, eq_run
  );

  modport slave (
    input  in_valid, less_than, equal_to, greater_than, clr, snap_req, snap_ready,
    output in_ready, snap_valid, snap_lt, snap_eq, snap_gt, snap_err, eq_run
  );
endinterface

// File: rtl/dvsd_cmp_stats.sv
// Saturating outcome counters for dvsd_cmp results with a read-and-clear snapshot port.
// Define DVSD_CMP_STATS_RUN_DETECT_EN to build the consecutive-equal run detector (eq_run).
module dvsd_cmp_stats #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RUN_LEN = 4
) (
  input logic            clk,
  input logic            rst_n,
  dvsd_cmp_stats_if.slave bus
);

  typedef enum logic {COUNT, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (RUN_LEN < 2 || RUN_LEN > 15) begin : g_run_len_check
    $error("RUN_LEN must lie in 2..15");
  end

  state_t           state, state_next;
  logic             accept, capture;
  logic             is_lt, is_eq, is_gt;
  logic [CNT_W-1:0] lt_cnt, eq_cnt, gt_cnt, err_cnt;
  logic [CNT_W-1:0] lt_next, eq_next, gt_next, err_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign bus.in_ready   = (state == COUNT);
  assign bus.snap_valid = (state == HOLD);
  assign accept         = bus.in_valid && bus.in_ready;
  // snap_req is only honoured in COUNT; in HOLD it is ignored.
  assign capture        = (state == COUNT) && bus.snap_req;

  assign is_lt = {bus.less_than, bus.equal_to, bus.greater_than} == 3'b100;
  assign is_eq = {bus.less_than, bus.equal_to, bus.greater_than} == 3'b010;
  assign is_gt = {bus.less_than, bus.equal_to, bus.greater_than} == 3'b001;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      COUNT:   if (bus.snap_req)   state_next = HOLD;
      HOLD:    if (bus.snap_ready) state_next = COUNT;
      default: state_next = COUNT;
    endcase
  end

  always_comb begin
    lt_next  = lt_cnt;
    eq_next  = eq_cnt;
    gt_next  = gt_cnt;
    err_next = err_cnt;
    if (bus.clr) begin
      lt_next  = '0;
      eq_next  = '0;
      gt_next  = '0;
      err_next = '0;
    end else if (accept) begin
      if (is_lt)      lt_next  = sat_inc(lt_cnt);
      else if (is_eq) eq_next  = sat_inc(eq_cnt);
      else if (is_gt) gt_next  = sat_inc(gt_cnt);
      else            err_next = sat_inc(err_cnt);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COUNT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_cnt  <= '0;
      eq_cnt  <= '0;
      gt_cnt  <= '0;
      err_cnt <= '0;
    end else if (capture) begin
      lt_cnt  <= '0;
      eq_cnt  <= '0;
      gt_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      lt_cnt  <= lt_next;
      eq_cnt  <= eq_next;
      gt_cnt  <= gt_next;
      err_cnt <= err_next;
    end
  end

  // NOTE: the snapshot registers are reset too, so a reset during HOLD discards a pending snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.snap_lt  <= '0;
      bus.snap_eq  <= '0;
      bus.snap_gt  <= '0;
      bus.snap_err <= '0;
    end else if (capture) begin
      bus.snap_lt  <= lt_next;
      bus.snap_eq  <= eq_next;
      bus.snap_gt  <= gt_next;
      bus.snap_err <= err_next;
    end
  end

`ifdef DVSD_CMP_STATS_RUN_DETECT_EN
  localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

  logic [3:0] run_cnt, run_next;
  logic       eq_run_q;

  always_comb begin
    run_next = run_cnt;
    if (bus.clr)     run_next = '0;
    else if (accept) run_next = !is_eq ? 4'd0 : (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      eq_run_q <= 1'b0;
    end else begin
      run_cnt  <= run_next;
      eq_run_q <= (run_next == RUN_MAX);
    end
  end

  assign bus.eq_run = eq_run_q;
`else
  assign bus.eq_run = 1'b0;
`endif

endmodule

// File: tb/tb_dvsd_cmp_stats.sv
// Directed + randomized self-checking bench for dvsd_cmp_stats against a count-level reference model.
module tb_dvsd_cmp_stats;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RUN_LEN = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef DVSD_CMP_STATS_RUN_DETECT_EN
  localparam bit RUN_EN = 1'b1;
`else
  localparam bit RUN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dvsd_cmp_stats_if #(.CNT_W(CNT_W)) bus ();

  dvsd_cmp_stats #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer counts and a held/not-held snapshot.
  int m_lt, m_eq, m_gt, m_err, m_run;
  int s_lt, s_eq, s_gt, s_err;
  bit m_hold;

  task automatic model_reset();
    m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0; m_run = 0;
    s_lt = 0; s_eq = 0; s_gt = 0; s_err = 0;
    m_hold = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_step();
    bit was_hold = m_hold;
    bit take     = bus.in_valid && !was_hold;
    int nflags   = int'(bus.less_than) + int'(bus.equal_to) + int'(bus.greater_than);
    if (bus.clr) begin
      m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0; m_run = 0;
    end else if (take) begin
      if (nflags != 1)           m_err = sat(m_err);
      else if (bus.less_than)    m_lt  = sat(m_lt);
      else if (bus.equal_to)     m_eq  = sat(m_eq);
      else                       m_gt  = sat(m_gt);
      if (nflags == 1 && bus.equal_to) m_run = (m_run >= RUN_LEN) ? RUN_LEN : m_run + 1;
      else                             m_run = 0;
    end
    if (was_hold && bus.snap_ready) m_hold = 0;
    if (!was_hold && bus.snap_req) begin
      s_lt = m_lt; s_eq = m_eq; s_gt = m_gt; s_err = m_err;
      m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0;
      m_hold = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"},   32'(bus.in_ready),   32'(!m_hold));
    check({tag, ".snap_valid"}, 32'(bus.snap_valid), 32'(m_hold));
    check({tag, ".snap_lt"},    32'(bus.snap_lt),    32'(s_lt));
    check({tag, ".snap_eq"},    32'(bus.snap_eq),    32'(s_eq));
    check({tag, ".snap_gt"},    32'(bus.snap_gt),    32'(s_gt));
    check({tag, ".snap_err"},   32'(bus.snap_err),   32'(s_err));
    check({tag, ".eq_run"},     32'(bus.eq_run),     32'(RUN_EN && (m_run == RUN_LEN)));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [2:0] f, input bit req, input bit rdy, input bit c);
    bus.in_valid     = v;
    bus.less_than    = f[2];
    bus.equal_to     = f[1];
    bus.greater_than = f[0];
    bus.snap_req     = req;
    bus.snap_ready   = rdy;
    bus.clr          = c;
  endtask

  localparam logic [2:0] F_LT = 3'b100, F_EQ = 3'b010, F_GT = 3'b001;

  initial begin
    logic [2:0] basic_seq [12];
    basic_seq = '{F_LT, F_LT, F_EQ, F_GT, F_LT, F_LT, F_EQ, F_GT, F_LT, F_GT, F_EQ, F_GT};

    // Reset
    drive(0, 3'b000, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    tick("post_reset");

    // Basic counts
    foreach (basic_seq[i]) begin
      drive(1, basic_seq[i], 0, 0, 0);
      tick($sformatf("basic[%0d]", i));
    end
    drive(0, 3'b000, 1, 0, 0);
    tick("basic_snap");
    check("basic.snap_valid", 32'(bus.snap_valid), 32'd1);
    check("basic.snap_lt",  32'(bus.snap_lt),  32'd5);
    check("basic.snap_eq",  32'(bus.snap_eq),  32'd3);
    check("basic.snap_gt",  32'(bus.snap_gt),  32'd4);
    check("basic.snap_err", 32'(bus.snap_err), 32'd0);
    drive(0, 3'b000, 0, 1, 0);
    tick("basic_release");
    check("basic.in_ready_back", 32'(bus.in_ready), 32'd1);

    // Backpressure: sample on the snap_req cycle is included, then a waiting gt sample
    drive(1, F_LT, 1, 0, 0);
    tick("bp_snap");
    for (int i = 0; i < 5; i++) begin
      drive(1, F_GT, 1, 0, 0);
      tick($sformatf("bp_hold[%0d]", i));
      check("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp.snap_lt_stable", 32'(bus.snap_lt), 32'd1);
    end
    drive(1, F_GT, 0, 1, 0);
    tick("bp_release");
    drive(1, F_GT, 0, 0, 0);
    tick("bp_waiting_accept");
    drive(0, 3'b000, 1, 0, 0);
    tick("bp_snap2");
    check("bp.snap_gt_waiting", 32'(bus.snap_gt), 32'd1);
    check("bp.snap_lt_cleared", 32'(bus.snap_lt), 32'd0);
    drive(0, 3'b000, 0, 1, 0);
    tick("bp_release2");

    // Illegal codes, then snap_req together with a legal gt sample
    drive(1, 3'b000, 0, 0, 0); tick("ill_000");
    drive(1, 3'b110, 0, 0, 0); tick("ill_110");
    drive(1, 3'b111, 0, 0, 0); tick("ill_111");
    drive(1, F_GT, 1, 0, 0);   tick("ill_snap");
    check("ill.snap_err", 32'(bus.snap_err), 32'd3);
    check("ill.snap_gt",  32'(bus.snap_gt),  32'd1);
    check("ill.snap_lt",  32'(bus.snap_lt),  32'd0);
    check("ill.snap_eq",  32'(bus.snap_eq),  32'd0);
    drive(0, 3'b000, 0, 1, 0); tick("ill_release");

    // Saturation
    for (int i = 0; i < CNT_MAX + 45; i++) begin
      drive(1, F_LT, 0, 0, 0);
      tick("sat_lt");
    end
    drive(0, 3'b000, 1, 0, 0); tick("sat_snap");
    check("sat.snap_lt", 32'(bus.snap_lt), 32'(CNT_MAX));
    drive(0, 3'b000, 0, 1, 0); tick("sat_release");

    // Run detector and clr
    for (int i = 0; i < 3; i++) begin
      drive(1, F_EQ, 0, 0, 0); tick("run_eq3");
    end
    drive(1, F_GT, 0, 0, 0); tick("run_gt");
    check("run.after_gt", 32'(bus.eq_run), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, F_EQ, 0, 0, 0); tick("run_eq4");
      check($sformatf("run.eq4[%0d]", i), 32'(bus.eq_run), 32'(RUN_EN && i == 3));
    end
    drive(1, F_EQ, 0, 0, 0); tick("run_eq5");
    check("run.extra_eq", 32'(bus.eq_run), 32'(RUN_EN));
    drive(1, F_EQ, 0, 0, 1); tick("run_clr");
    check("run.clr", 32'(bus.eq_run), 32'd0);
    drive(1, F_EQ, 1, 0, 1); tick("run_clr_snap");
    check("clr_snap.snap_valid", 32'(bus.snap_valid), 32'd1);
    check("clr_snap.snap_eq",  32'(bus.snap_eq),  32'd0);
    check("clr_snap.snap_lt",  32'(bus.snap_lt),  32'd0);
    check("clr_snap.snap_gt",  32'(bus.snap_gt),  32'd0);
    check("clr_snap.snap_err", 32'(bus.snap_err), 32'd0);
    drive(0, 3'b000, 0, 1, 0); tick("clr_snap_release");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7) < 6 ? (3'b001 << $urandom_range(0, 2)) : $urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0));
      tick("rand");
    end
    drive(0, 3'b000, 0, 1, 1); tick("rand_drain");

    // Asynchronous reset while holding a snapshot
    for (int i = 0; i < 7; i++) begin
      drive(1, F_EQ, 0, 0, 0); tick("rst_eq");
    end
    drive(0, 3'b000, 1, 0, 0); tick("rst_snap");
    check("rst.snap_eq_before", 32'(bus.snap_eq), 32'd7);
    drive(0, 3'b000, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.snap_valid", 32'(bus.snap_valid), 32'd0);
    check("rst.snap_eq",    32'(bus.snap_eq),    32'd0);
    check("rst.in_ready",   32'(bus.in_ready),   32'd1);
    @(negedge clk);
    check_all("rst_held");
    rst_n = 1'b1;
    drive(1, F_LT, 0, 0, 0); tick("rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
